// File: rtl/speaker_pkg.sv
// Shared definitions for the speaker FIFO: CPU and play FSM encodings, decay field width.
package speaker_pkg;

  typedef enum logic [1:0] {
    CPU_RESET,
    CPU_IDLE,
    CPU_PUSH,
    CPU_RESP
  } cpu_state_t;

  typedef enum logic [2:0] {
    PLAY_RESET,
    PLAY0,
    PLAY1,
    LOAD,
    PULSE0,
    PULSE1
  } play_state_t;

  localparam int DECAY_W = 12;

endpackage

// File: rtl/speaker_sample_fifo.sv
// Synchronous sample FIFO with registered occupancy; push when full and pop when empty are ignored.
module speaker_sample_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (en && do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (en) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        if (do_push && !do_pop)      level <= level + 1'b1;
        else if (do_pop && !do_push) level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/speaker_fifo.sv
// CPU handshake into a sample FIFO, serialised MSB-first to a WM8731 DAC once per 8.1 kHz frame.
// Define SPEAKER_DECAY_EN to make underrun replays decay toward zero instead of repeating.
module speaker_fifo import speaker_pkg::*; #(
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int STEREO     = 0
) (
  input  logic                          clock_25m,
  input  logic                          reset_25m,
  input  logic                          clock_valid,
  input  logic                          clock_8_1k,
  input  logic                          codec_initialized,
  input  logic                          speaker_command,
  output logic                          speaker_response,
  input  logic [31:0]                   speaker_sample,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          AUD_XCK,
  output logic                          AUD_BCLK,
  output logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT
);
  localparam int FW = 2 * SAMPLE_W;

  cpu_state_t    cpu_state, cpu_next;
  play_state_t   play_state, play_next;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_din, fifo_dout, hold, shift, replay, load_val;
  logic          bclk, lrck, frame_prev, frame_edge;
  logic          sample_edge, do_shift, do_load, lr_toggle;
  logic [1:0]    sync_8_1k;
  logic [SAMPLE_W-1:0] left, right;
  logic          sample_unused;

  assign sample_unused = ^speaker_sample;

  always_comb begin
    left  = '0;
    right = '0;
    if (STEREO != 0) begin
      left[SAMPLE_W-1 -: 16]  = speaker_sample[31:16];
      right[SAMPLE_W-1 -: 16] = speaker_sample[15:0];
    end else begin
      left  = speaker_sample[31 -: SAMPLE_W];
      right = speaker_sample[31 -: SAMPLE_W];
    end
    fifo_din = {left, right};
  end

  speaker_sample_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clock_25m),
    .rst   (reset_25m),
    .en    (clock_valid),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // CPU handshake FSM
  always_ff @(posedge clock_25m) begin
    if (clock_valid) begin
      if (reset_25m) cpu_state <= CPU_RESET;
      else           cpu_state <= cpu_next;
    end
  end

  always_comb begin
    cpu_next = cpu_state;
    case (cpu_state)
      CPU_RESET: cpu_next = CPU_IDLE;
      CPU_IDLE:  if (speaker_command && codec_initialized && !fifo_full) cpu_next = CPU_PUSH;
      CPU_PUSH:  cpu_next = CPU_RESP;
      CPU_RESP:  if (!speaker_command) cpu_next = CPU_IDLE;
      default:   cpu_next = CPU_RESET;
    endcase
  end

  always_comb begin
    fifo_push = (cpu_state == CPU_PUSH);
  end

  always_ff @(posedge clock_25m) begin
    if (clock_valid) begin
      if (reset_25m) speaker_response <= 1'b0;
      else           speaker_response <= (cpu_state == CPU_RESP) && speaker_command;
    end
  end

  // Play FSM: PLAY0/PLAY1 track the BCLK phase; LOAD..PULSE1 frame one BCLK of DACLRCK high.
  always_ff @(posedge clock_25m) begin
    if (clock_valid) begin
      if (reset_25m) play_state <= PLAY_RESET;
      else           play_state <= play_next;
    end
  end

  always_comb begin
    play_next = play_state;
    case (play_state)
      PLAY_RESET: play_next = bclk ? PLAY0 : PLAY1;
      PLAY0:      play_next = frame_edge ? LOAD : PLAY1;
      PLAY1:      play_next = PLAY0;
      LOAD:       play_next = PULSE0;
      PULSE0:     play_next = PULSE1;
      PULSE1:     play_next = PLAY0;
      default:    play_next = PLAY_RESET;
    endcase
  end

  always_comb begin
    sample_edge = (play_state == PLAY0);
    do_shift    = (play_state == PLAY1);
    do_load     = (play_state == LOAD);
    lr_toggle   = (play_state == LOAD) || (play_state == PULSE1);
  end

  assign fifo_pop   = do_load;
  assign frame_edge = sync_8_1k[1] && !frame_prev;

`ifdef SPEAKER_DECAY_EN
  function automatic logic [SAMPLE_W-1:0] decay(input logic [SAMPLE_W-1:0] s);
    logic [DECAY_W-1:0]  f;
    logic [SAMPLE_W-1:0] r;
    f = s[SAMPLE_W-2 -: DECAY_W];
    if (!s[SAMPLE_W-1] && (f != '0))     f = f - 1'b1;
    else if (s[SAMPLE_W-1] && (f != '1)) f = f + 1'b1;
    r = {SAMPLE_W{s[SAMPLE_W-1]}};
    r[SAMPLE_W-2 -: DECAY_W] = f;
    return r;
  endfunction

  assign replay = {decay(hold[FW-1 -: SAMPLE_W]), decay(hold[SAMPLE_W-1:0])};
`else
  assign replay = hold;
`endif

  assign load_val = fifo_empty ? replay : fifo_dout;

  always_ff @(posedge clock_25m) begin
    if (clock_valid) begin
      if (reset_25m) begin
        bclk       <= 1'b0;
        lrck       <= 1'b0;
        sync_8_1k  <= 2'b00;
        frame_prev <= 1'b0;
        hold       <= '0;
        shift      <= '0;
        underrun   <= 1'b0;
      end else begin
        bclk      <= ~bclk;
        sync_8_1k <= {sync_8_1k[0], clock_8_1k};
        if (sample_edge) frame_prev <= sync_8_1k[1];
        if (lr_toggle)   lrck <= ~lrck;
        if (do_load) begin
          hold  <= load_val;
          shift <= load_val;
          if (fifo_empty) underrun <= 1'b1;
        end else if (do_shift) begin
          shift <= {shift[FW-2:0], shift[FW-1]};
        end
      end
    end
  end

  assign AUD_BCLK    = bclk;
  assign AUD_XCK     = bclk;
  assign AUD_DACLRCK = lrck;
  assign AUD_DACDAT  = shift[FW-1];

endmodule

// File: tb/tb_speaker_fifo.sv
// Directed bench for speaker_fifo: a mono and a stereo instance share the CPU and frame stimulus.
module tb_speaker_fifo;
  logic        clock_25m = 1'b0;
  logic        reset_25m = 1'b1;
  logic        clock_valid = 1'b1;
  logic        clock_8_1k = 1'b0;
  logic        codec_initialized = 1'b1;
  logic        speaker_command = 1'b0;
  logic [31:0] speaker_sample = '0;

  logic       m_resp, m_under, m_xck, m_bclk, m_lrck, m_dat;
  logic [3:0] m_level;
  logic       s_resp, s_under, s_xck, s_bclk, s_lrck, s_dat;
  logic [3:0] s_level;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock_25m = ~clock_25m;

  speaker_fifo #(.SAMPLE_W(24), .FIFO_DEPTH(8), .STEREO(0)) u_mono (
    .clock_25m(clock_25m), .reset_25m(reset_25m), .clock_valid(clock_valid),
    .clock_8_1k(clock_8_1k), .codec_initialized(codec_initialized),
    .speaker_command(speaker_command), .speaker_response(m_resp), .speaker_sample(speaker_sample),
    .fifo_level(m_level), .underrun(m_under), .AUD_XCK(m_xck), .AUD_BCLK(m_bclk),
    .AUD_DACLRCK(m_lrck), .AUD_DACDAT(m_dat)
  );

  speaker_fifo #(.SAMPLE_W(24), .FIFO_DEPTH(8), .STEREO(1)) u_stereo (
    .clock_25m(clock_25m), .reset_25m(reset_25m), .clock_valid(clock_valid),
    .clock_8_1k(clock_8_1k), .codec_initialized(codec_initialized),
    .speaker_command(speaker_command), .speaker_response(s_resp), .speaker_sample(speaker_sample),
    .fifo_level(s_level), .underrun(s_under), .AUD_XCK(s_xck), .AUD_BCLK(s_bclk),
    .AUD_DACLRCK(s_lrck), .AUD_DACDAT(s_dat)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock_25m);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_25m = 1'b1;
    clock_valid = 1'b1;
    speaker_command = 1'b0;
    clock_8_1k = 1'b0;
    codec_initialized = 1'b1;
    step(3);
    reset_25m = 1'b0;
    step(3);
  endtask

  // Returns cycles from command assert to response, then completes the handshake.
  task automatic push_word(input logic [31:0] w, output int lat);
    int n;
    lat = 0;
    speaker_sample = w;
    speaker_command = 1'b1;
    do begin
      step(1);
      lat++;
    end while (m_resp !== 1'b1 && lat < 30);
    speaker_command = 1'b0;
    n = 0;
    while (m_resp !== 1'b0 && n < 10) begin
      step(1);
      n++;
    end
  endtask

  task automatic capture_frame(output logic [47:0] mb, output logic [47:0] sb,
                               output int lr_cycles, output bit ok);
    int n;
    ok = 1'b1;
    lr_cycles = 0;
    mb = '0;
    sb = '0;
    clock_8_1k = 1'b1;
    n = 0;
    while (m_lrck !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    clock_8_1k = 1'b0;
    if (n >= 40) ok = 1'b0;
    n = 0;
    while (m_lrck === 1'b1 && n < 40) begin
      lr_cycles++;
      step(1);
      n++;
    end
    for (int i = 0; i < 48; i++) begin
      step(1);
      if (m_bclk !== 1'b1) step(1);
      mb = {mb[46:0], m_dat};
      sb = {sb[46:0], s_dat};
    end
  endtask

  task automatic test_reset();
    reset_25m = 1'b1;
    clock_valid = 1'b1;
    step(3);
    tests_run++;
    if (m_bclk !== 1'b0) begin tests_failed++; $display("FAIL reset_bclk: got %b expected 0", m_bclk); end
    tests_run++;
    if (m_xck !== 1'b0) begin tests_failed++; $display("FAIL reset_xck: got %b expected 0", m_xck); end
    tests_run++;
    if (m_lrck !== 1'b0) begin tests_failed++; $display("FAIL reset_lrck: got %b expected 0", m_lrck); end
    tests_run++;
    if (m_resp !== 1'b0) begin tests_failed++; $display("FAIL reset_resp: got %b expected 0", m_resp); end
    tests_run++;
    if (m_under !== 1'b0) begin tests_failed++; $display("FAIL reset_underrun: got %b expected 0", m_under); end
    tests_run++;
    if (m_level !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", m_level); end
    reset_25m = 1'b0;
    step(3);
  endtask

  task automatic test_clock_valid();
    reset_25m = 1'b1;
    step(2);
    reset_25m = 1'b0;
    clock_valid = 1'b0;
    speaker_command = 1'b1;
    speaker_sample = 32'h11223300;
    step(8);
    tests_run++;
    if (m_bclk !== 1'b0) begin tests_failed++; $display("FAIL gated_bclk: got %b expected 0", m_bclk); end
    tests_run++;
    if (m_level !== 4'd0 || m_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL gated_push: level %0d resp %b expected 0 0", m_level, m_resp);
    end
    speaker_command = 1'b0;
    clock_valid = 1'b1;
    step(1);
    tests_run++;
    if (m_bclk !== 1'b1) begin tests_failed++; $display("FAIL enabled_bclk: got %b expected 1", m_bclk); end
    step(3);
  endtask

  task automatic test_codec_not_ready();
    do_reset();
    codec_initialized = 1'b0;
    speaker_sample = 32'hDEADBE00;
    speaker_command = 1'b1;
    step(20);
    tests_run++;
    if (m_resp !== 1'b0) begin tests_failed++; $display("FAIL noinit_resp: got %b expected 0", m_resp); end
    tests_run++;
    if (m_level !== 4'd0) begin tests_failed++; $display("FAIL noinit_level: got %0d expected 0", m_level); end
    speaker_command = 1'b0;
    codec_initialized = 1'b1;
    step(2);
  endtask

  task automatic test_mono();
    int lat, lr;
    bit ok;
    logic [47:0] mb, sb;
    do_reset();
    push_word(32'h12345600, lat);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL mono_resp_latency: got %0d expected 3", lat); end
    tests_run++;
    if (m_level !== 4'd1) begin tests_failed++; $display("FAIL mono_level_push: got %0d expected 1", m_level); end
    capture_frame(mb, sb, lr, ok);
    tests_run++;
    if (!ok || mb !== 48'h123456123456) begin
      tests_failed++;
      $display("FAIL mono_frame: got %h expected 123456123456", mb);
    end
    tests_run++;
    if (lr !== 2) begin tests_failed++; $display("FAIL mono_lrck_width: got %0d expected 2", lr); end
    tests_run++;
    if (sb !== 48'h123400560000) begin
      tests_failed++;
      $display("FAIL stereo_split: got %h expected 123400560000", sb);
    end
    tests_run++;
    if (m_level !== 4'd0 || m_under !== 1'b0) begin
      tests_failed++;
      $display("FAIL mono_after_pop: level %0d underrun %b expected 0 0", m_level, m_under);
    end
  endtask

  task automatic test_stereo();
    int lat, lr;
    bit ok;
    logic [47:0] mb, sb;
    do_reset();
    push_word(32'hAAAA5555, lat);
    capture_frame(mb, sb, lr, ok);
    tests_run++;
    if (!ok || sb !== 48'hAAAA00555500) begin
      tests_failed++;
      $display("FAIL stereo_frame: got %h expected aaaa00555500", sb);
    end
    tests_run++;
    if (mb !== 48'hAAAA55AAAA55) begin
      tests_failed++;
      $display("FAIL stereo_mono_frame: got %h expected aaaa55aaaa55", mb);
    end
  endtask

  task automatic test_underrun();
    int lat, lr;
    bit ok;
    logic [47:0] mb, sb, exp;
    do_reset();
    push_word(32'h7FF80000, lat);
    capture_frame(mb, sb, lr, ok);
    tests_run++;
    if (mb !== 48'h7FF8007FF800 || m_under !== 1'b0) begin
      tests_failed++;
      $display("FAIL underrun_first: got %h/%b expected 7ff8007ff800/0", mb, m_under);
    end
`ifdef SPEAKER_DECAY_EN
    exp = 48'h7FF0007FF000;
`else
    exp = 48'h7FF8007FF800;
`endif
    capture_frame(mb, sb, lr, ok);
    tests_run++;
    if (!ok || mb !== exp) begin
      tests_failed++;
      $display("FAIL underrun_replay: got %h expected %h", mb, exp);
    end
    tests_run++;
    if (m_under !== 1'b1) begin tests_failed++; $display("FAIL underrun_flag: got %b expected 1", m_under); end
  endtask

  task automatic test_full();
    int lat, lr, bad;
    bit ok;
    logic [47:0] mb, sb;
    do_reset();
    bad = 0;
    for (int i = 1; i <= 8; i++) begin
      push_word(32'(i) << 24, lat);
      if (lat != 3) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL full_fill_latency: got %0d slow pushes expected 0", bad); end
    tests_run++;
    if (m_level !== 4'd8) begin tests_failed++; $display("FAIL full_level: got %0d expected 8", m_level); end
    speaker_sample = 32'h09000000;
    speaker_command = 1'b1;
    step(30);
    tests_run++;
    if (m_resp !== 1'b0 || m_level !== 4'd8) begin
      tests_failed++;
      $display("FAIL full_withheld: resp %b level %0d expected 0 8", m_resp, m_level);
    end
    capture_frame(mb, sb, lr, ok);
    tests_run++;
    if (!ok || mb !== 48'h010000010000) begin
      tests_failed++;
      $display("FAIL full_first_pop: got %h expected 010000010000", mb);
    end
    tests_run++;
    if (m_resp !== 1'b1 || m_level !== 4'd8) begin
      tests_failed++;
      $display("FAIL full_ninth: resp %b level %0d expected 1 8", m_resp, m_level);
    end
    speaker_command = 1'b0;
    step(3);
  endtask

  task automatic test_reset_mid();
    int lat, lr, n;
    bit ok;
    logic [47:0] mb, sb;
    do_reset();
    capture_frame(mb, sb, lr, ok);
    for (int i = 0; i < 3; i++) push_word(32'hF0F0F000 + 32'(i), lat);
    tests_run++;
    if (m_level !== 4'd3 || m_under !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_setup: level %0d underrun %b expected 3 1", m_level, m_under);
    end
    clock_8_1k = 1'b1;
    n = 0;
    while (m_lrck !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    clock_8_1k = 1'b0;
    speaker_command = 1'b1;
    speaker_sample = 32'h55555500;
    reset_25m = 1'b1;
    step(1);
    tests_run++;
    if (n >= 40 || m_bclk !== 1'b0 || m_lrck !== 1'b0 || m_dat !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_pins: bclk %b lrck %b dat %b expected 0 0 0", m_bclk, m_lrck, m_dat);
    end
    tests_run++;
    if (m_resp !== 1'b0 || m_under !== 1'b0 || m_level !== 4'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_state: resp %b underrun %b level %0d expected 0 0 0", m_resp, m_under, m_level);
    end
    speaker_command = 1'b0;
    step(2);
    reset_25m = 1'b0;
    step(3);
    capture_frame(mb, sb, lr, ok);
    tests_run++;
    if (!ok || mb !== 48'h0 || m_level !== 4'd0) begin
      tests_failed++;
      $display("FAIL mid_discard: frame %h level %0d expected 0 0", mb, m_level);
    end
  endtask

  initial begin
    test_reset();
    test_clock_valid();
    test_codec_not_ready();
    test_mono();
    test_stereo();
    test_underrun();
    test_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/speaker_fifo.md
SPEAKER_FIFO -- requirements
Module: speaker_fifo

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 24: bits sent per channel per frame, legal 16..32.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: sample FIFO entries, power of two, 2..64.
REQ-003 SHALL have parameter STEREO, default 0: 0 mono (one sample on both channels), 1 separate left/right.
REQ-004 SHALL have ports: clock_25m in 1 system clock; reset_25m in 1 reset, synchronous, active-high; clock_valid in 1 global enable.
REQ-005 SHALL have ports: clock_8_1k in 1 asynchronous frame-rate clock; codec_initialized in 1 codec ready.
REQ-006 SHALL have ports: speaker_command in 1 CPU request; speaker_response out 1 CPU acknowledge; speaker_sample in 32 CPU sample word.
REQ-007 SHALL have ports: fifo_level out $clog2(FIFO_DEPTH)+1 occupancy; underrun out 1 sticky empty-at-frame flag.
REQ-008 SHALL have ports: AUD_XCK, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, all out 1, WM8731 DAC pins.

Function
REQ-009 SHALL update no register while clock_valid=0.
REQ-010 SHALL toggle AUD_BCLK every enabled cycle; AUD_XCK SHALL equal AUD_BCLK.
REQ-011 SHALL pass clock_8_1k through a 2-flop synchronizer, sampling the synchronized value for edge detection only in PLAY0.
REQ-012 CPU FSM SHALL have states RESET->IDLE; IDLE->PUSH when speaker_command=1, codec_initialized=1 and FIFO not full, else stay IDLE; PUSH->RESP.
REQ-013 PUSH SHALL write one entry: mono speaker_sample[31:32-SAMPLE_W]; stereo left=[31:16], right=[15:0], each left-justified, zero-padded to SAMPLE_W.
REQ-014 RESP SHALL register speaker_response=1 (one cycle after entry) and stay until speaker_command=0, then go IDLE.
REQ-015 Play FSM SHALL have states RESET, PLAY0 (BCLK=0), PLAY1 (BCLK=1), LOAD, PULSE0, PULSE1; RESET->PLAY1 if BCLK=0 else PLAY0.
REQ-016 PLAY0->LOAD on synchronized 8.1k rising edge, else PLAY1; PLAY1 shifts left one bit, ->PLAY0.
REQ-017 LOAD SHALL load the 2*SAMPLE_W shift register {left,right} (mono: sample duplicated), toggle AUD_DACLRCK, ->PULSE0->PULSE1; PULSE1 toggles AUD_DACLRCK, ->PLAY0.
REQ-018 AUD_DACDAT SHALL equal shift-register MSB; shift SHALL wrap MSB into LSB.
REQ-019 LOAD with FIFO non-empty SHALL pop one entry and latch it as hold sample.
REQ-020 LOAD with FIFO empty SHALL reload hold sample and set underrun; underrun clears only on reset.
REQ-021 Simultaneous PUSH and LOAD pop SHALL both occur; fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-022 Full FIFO SHALL hold CPU FSM in IDLE without loss; no overflow possible.

Reset
REQ-023 Reset SHALL give AUD_BCLK=0, AUD_DACLRCK=0, speaker_response=0, underrun=0, fifo_level=0, hold sample=0, both FSMs RESET.
REQ-024 Reset mid-frame or mid-handshake SHALL discard FIFO contents and the in-flight CPU word.

Configuration
REQ-025 With SPEAKER_DECAY_EN defined, each underrun LOAD SHALL step hold field [SAMPLE_W-2:SAMPLE_W-13] by 1 toward 0 (positive) or all-ones (negative), fill lower bits with sign, per channel.
REQ-026 Without SPEAKER_DECAY_EN, underrun LOAD SHALL replay hold sample unchanged.

Structure
REQ-027 Package speaker_pkg SHALL hold both FSM state encodings and the 12-bit decay-field width constant.
REQ-028 FIFO SHALL be sub-module speaker_sample_fifo (sync, registered level, push/pop/full/empty).

Verification
REQ-029 Mono defaults, push 0x12345600 after init -> response next cycle, frame AUD_DACDAT = 0x123456 MSB-first twice, DACLRCK one BCLK high.
REQ-030 STEREO=1, push 0xAAAA5555 -> left 0xAAAA00, right 0x555500 per frame.
REQ-031 Push 9 words, FIFO_DEPTH=8, no frames -> 9th response withheld until first frame pops; fifo_level 8 then 8.
REQ-032 Empty FIFO with SPEAKER_DECAY_EN, hold 0x7FF800 -> next frame 0x7FF000, underrun=1; without macro 0x7FF800 repeated.
REQ-033 codec_initialized=0 with speaker_command=1 -> no response, fifo_level 0.
REQ-034 reset_25m mid-frame with level 3 -> all outputs at reset values next cycle, level 0.
